// File: rtl/cfg_seq_pkg.sv
// Shared types and register map for the config write sequencer.
package cfg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    SEND_HI,
    WAIT_START,
    WAIT_DONE
  } state_e;

  localparam logic [5:0] ADDR_LOADER_LO = 6'h08;
  localparam logic [5:0] ADDR_LOADER_HI = 6'h0C;
  localparam logic [5:0] ADDR_STAGE_LO  = 6'h10;
  localparam logic [5:0] ADDR_PUSH_HI   = 6'h14;
  localparam logic [5:0] ADDR_CTRL      = 6'h18;

  localparam int ENTRY_W = 48;
  typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/cfg_seq_fifo.sv
// Entry queue for the sequencer; flush takes effect before a same-cycle push.
module cfg_seq_fifo
  import cfg_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] waddr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (flush || !full || pop_ok);
  assign waddr   = flush ? '0 : wptr;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= push_ok ? PW'(1) : '0;
      count <= push_ok ? (PW+1)'(1) : '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[waddr] <= push_data;
  end

endmodule

// File: rtl/cfg_write_sequencer.sv
// Host-to-loader config write sequencer: queues 48-bit entries and replays each as a LO/HI write pair.
// Optional build macro CFG_SEQ_DONE_IRQ_EN enables the done_irq completion pulse.
module cfg_write_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_wr,
  input  logic [5:0]               host_addr,
  input  logic [31:0]              host_wdata,
  output logic                     write_req,
  output logic [5:0]               address,
  output logic [31:0]              data_out,
  input  logic                     loader_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     overflow,
  output logic                     idle,
  output logic                     done_irq
);

  state_e      state;
  entry_t      cur_entry;
  entry_t      head;
  logic [31:0] staged_lo;
  logic        inflight_live;
  logic        fifo_empty;
  logic        wr_stage, wr_push, wr_ctrl;
  logic        flush, ovf_clr, pop, pop_eff, drop, start;

  assign wr_stage = host_wr && (host_addr == ADDR_STAGE_LO);
  assign wr_push  = host_wr && (host_addr == ADDR_PUSH_HI);
  assign wr_ctrl  = host_wr && (host_addr == ADDR_CTRL);
  assign flush    = wr_ctrl && host_wdata[1];
  assign ovf_clr  = wr_ctrl && host_wdata[0];

  // A flushed entry must not be popped later, or it would take a newer entry with it.
  assign pop      = (state == SEND_HI) && inflight_live;
  assign pop_eff  = pop && !fifo_empty && !flush;
  assign drop     = wr_push && full && !pop_eff && !flush;
  assign start    = (state == IDLE) && !fifo_empty && !loader_busy && !flush;
  assign idle     = fifo_empty && (state == IDLE) && !loader_busy;

  cfg_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_push),
    .push_data ({host_wdata[15:0], staged_lo}),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged_lo <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_stage) staged_lo <= host_wdata;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) cur_entry <= head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      inflight_live <= 1'b0;
      write_req     <= 1'b0;
      address       <= '0;
      data_out      <= '0;
    end else begin
      write_req <= 1'b0;
      address   <= '0;
      data_out  <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= SEND_LO;
            inflight_live <= 1'b1;
            write_req     <= 1'b1;
            address       <= ADDR_LOADER_LO;
            data_out      <= head[31:0];
          end
        end
        SEND_LO: begin
          state     <= SEND_HI;
          write_req <= 1'b1;
          address   <= ADDR_LOADER_HI;
          data_out  <= {16'h0, cur_entry[47:32]};
          if (flush) inflight_live <= 1'b0;
        end
        SEND_HI: begin
          state         <= WAIT_START;
          inflight_live <= 1'b0;
        end
        WAIT_START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!loader_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CFG_SEQ_DONE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_irq <= 1'b0;
    end else begin
      done_irq <= (state == WAIT_DONE) && !loader_busy && (fifo_empty || flush) && !wr_push;
    end
  end
`else
  assign done_irq = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_write_sequencer.sv
// Scoreboard bench for cfg_write_sequencer: directed pushes queue expected loader writes, a monitor checks them.
module tb_cfg_write_sequencer;
  import cfg_seq_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   host_wr = 1'b0;
  logic [5:0]             host_addr = '0;
  logic [31:0]            host_wdata = '0;
  logic                   force_busy = 1'b0;
  logic                   model_busy = 1'b0;
  logic                   loader_busy;
  logic                   write_req;
  logic [5:0]             address;
  logic [31:0]            data_out;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   full, overflow, idle, done_irq;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  wr_seen = 0;
  int  irq_seen = 0;
  int  busy_len = 3;
  int  base_wr, base_irq;

  assign loader_busy = force_busy | model_busy;

  cfg_write_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .write_req   (write_req),
    .address     (address),
    .data_out    (data_out),
    .loader_busy (loader_busy),
    .fifo_count  (fifo_count),
    .full        (full),
    .overflow    (overflow),
    .idle        (idle),
    .done_irq    (done_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [31:0] d);
    host_wr = 1'b1;
    host_addr = a;
    host_wdata = d;
    step();
    host_wr = 1'b0;
    host_addr = '0;
    host_wdata = '0;
  endtask

  task automatic push_entry(input logic [31:0] lo, input logic [15:0] hi, input bit expect_it);
    host_write(ADDR_STAGE_LO, lo);
    host_write(ADDR_PUSH_HI, {16'h0, hi});
    if (expect_it) begin
      exp_q.push_back({ADDR_LOADER_LO, lo});
      exp_q.push_back({ADDR_LOADER_HI, {16'h0, hi}});
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (idle !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    check("idle_reached", 32'(idle), 32'd1);
    step();
    step();
  endtask

  task automatic wait_seen(input int target, input int maxc);
    int n = 0;
    while (wr_seen < target && n < maxc) begin
      step();
      n++;
    end
    check("req_arrived", 32'(wr_seen >= target), 32'd1);
  endtask

  // Monitor: every loader write is popped against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (done_irq === 1'b1) irq_seen++;
      if (write_req === 1'b1) begin
        wr_seen++;
        check("busy_at_req", 32'(loader_busy), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got %0h/%0h want none", address, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("req_addr", 32'(address), 32'(mon_e.a));
          check("req_data", data_out, mon_e.d);
        end
      end
    end
  end

  // Loader model: busy rises one cycle after the HI write and holds for busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (write_req === 1'b1 && address == ADDR_LOADER_HI) begin
        @(posedge clk);
        #2;
        model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #2;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_req", 32'(write_req), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_done_irq", 32'(done_irq), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_full", 32'(full), 32'd0);

    // Basic load with latency check
    base_irq = irq_seen;
    push_entry(32'hDEADBEEF, 16'h1234, 1'b1);
    check("lat_n", 32'(write_req), 32'd0);
    step();
    check("lat_n1_req", 32'(write_req), 32'd1);
    check("lat_n1_addr", 32'(address), 32'h08);
    step();
    check("lat_n2_req", 32'(write_req), 32'd1);
    check("lat_n2_addr", 32'(address), 32'h0C);
    wait_idle(40);
    check("basic_count", 32'(fifo_count), 32'd0);
`ifdef CFG_SEQ_DONE_IRQ_EN
    check("done_irq_pulses", 32'(irq_seen - base_irq), 32'd1);
`else
    check("done_irq_off", 32'(irq_seen), 32'd0);
`endif

    // Back-pressure
    force_busy = 1'b1;
    base_wr = wr_seen;
    push_entry(32'h0000_0001, 16'hA001, 1'b1);
    push_entry(32'h0000_0002, 16'hA002, 1'b1);
    push_entry(32'h0000_0003, 16'hA003, 1'b1);
    repeat (5) step();
    check("bp_held", 32'(wr_seen), 32'(base_wr));
    check("bp_count", 32'(fifo_count), 32'd3);
    check("bp_full", 32'(full), 32'd0);
    force_busy = 1'b0;
    wait_idle(100);
    check("bp_pairs", 32'(wr_seen - base_wr), 32'd6);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Overflow
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++)
      push_entry(32'hC000_0000 + 32'(i), 16'(16'hB000 + i), i < DEPTH);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_set", 32'(overflow), 32'd1);
    host_write(ADDR_CTRL, 32'h1);
    check("ovf_clear", 32'(overflow), 32'd0);
    check("ovf_still_full", 32'(full), 32'd1);
    force_busy = 1'b0;
    wait_idle(150);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // Flush during WAIT_DONE
    busy_len = 6;
    base_wr = wr_seen;
    push_entry(32'h1111_AAAA, 16'h0AAA, 1'b1);
    push_entry(32'h2222_BBBB, 16'h0BBB, 1'b0);
    wait_seen(base_wr + 2, 20);
    step();
    check("flush_pre_count", 32'(fifo_count), 32'd1);
    host_write(ADDR_CTRL, 32'h2);
    check("flush_count", 32'(fifo_count), 32'd0);
    wait_idle(60);
    check("flush_no_more", 32'(wr_seen - base_wr), 32'd2);
    busy_len = 3;

    // Reset while in SEND_HI
    host_write(ADDR_STAGE_LO, 32'h3333_4444);
    host_write(ADDR_PUSH_HI, 32'h0000_5555);
    exp_q.push_back({ADDR_LOADER_LO, 32'h3333_4444});
    n = 0;
    while (!(write_req === 1'b1 && address == ADDR_LOADER_HI) && n < 10) begin
      step();
      n++;
    end
    check("midrst_in_send_hi", 32'(address), 32'h0C);
    rst_n = 1'b0;
    #1;
    check("midrst_write_req", 32'(write_req), 32'd0);
    check("midrst_address", 32'(address), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_no_req", 32'(write_req), 32'd0);

    // staged_lo was cleared by reset: push without staging
    host_write(ADDR_PUSH_HI, 32'h0000_ABCD);
    exp_q.push_back({ADDR_LOADER_LO, 32'h0});
    exp_q.push_back({ADDR_LOADER_HI, 32'h0000_ABCD});
    wait_idle(40);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
`ifndef CFG_SEQ_DONE_IRQ_EN
    check("done_irq_never", 32'(irq_seen), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
